// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: machine word, fetch FSM states
// and the sequential PC increment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD       = 2'd1,
    REDIR_PEND = 2'd2,
    HALTED     = 2'd3
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache request and
// feeds the IF/ID latch, absorbing ID stalls and redirects during misses.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall_id,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic [WORD_W-1:0] imemload_out,
  output logic [WORD_W-1:0] pcp4_out,
  output logic [WORD_W-1:0] pc_out
);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_hold_word;
  logic [WORD_W-1:0] r_pend_pc;

  logic [WORD_W-1:0] w_tgt;
  logic [WORD_W-1:0] w_pcp4;

  assign w_tgt    = {redirect_pc[WORD_W-1:2], 2'b00};
  assign w_pcp4   = r_pc + WORD_W'(PC_STEP);
  assign imemaddr = r_pc;
  assign pc_out   = r_pc;
  assign pcp4_out = w_pcp4;

  // A redirect during a miss keeps the old address on the bus until the
  // cache returns, so the outstanding fill completes before the jump.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_pc        <= PC_INIT;
      r_hold_word <= {WORD_W{1'b0}};
      r_pend_pc   <= {WORD_W{1'b0}};
    end else begin
      case (r_state)
        RUN: begin
          if (halt) begin
            r_state <= HALTED;
          end else if (redirect) begin
            if (ihit) begin
              r_pc <= w_tgt;
            end else begin
              r_pend_pc <= w_tgt;
              r_state   <= REDIR_PEND;
            end
          end else if (ihit) begin
            if (stall_id) begin
              r_hold_word <= imemload;
              r_state     <= HOLD;
            end else begin
              r_pc <= w_pcp4;
            end
          end
        end
        HOLD: begin
          if (halt) begin
            r_state <= HALTED;
          end else if (redirect) begin
            r_hold_word <= {WORD_W{1'b0}};
            r_pc        <= w_tgt;
            r_state     <= RUN;
          end else if (!stall_id) begin
            r_pc    <= w_pcp4;
            r_state <= RUN;
          end
        end
        REDIR_PEND: begin
          if (halt) begin
            r_state <= HALTED;
          end else if (redirect) begin
            if (ihit) begin
              r_pc    <= w_tgt;
              r_state <= RUN;
            end else begin
              r_pend_pc <= w_tgt;
            end
          end else if (ihit) begin
            r_pc    <= r_pend_pc;
            r_state <= RUN;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Latch controls and I-cache request decoded from state and inputs.
  always_comb begin
    iREN         = 1'b0;
    if_id_enable = 1'b0;
    if_id_flush  = 1'b0;
    imemload_out = (r_state == HOLD) ? r_hold_word : imemload;
    if (RST) begin
      iREN         = 1'b0;
      if_id_enable = 1'b0;
      if_id_flush  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          iREN = 1'b1;
          if (halt) begin
            if_id_flush = 1'b0;
          end else if (redirect) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_enable = ihit & ~stall_id;
          end
        end
        HOLD: begin
          if (halt) begin
            if_id_flush = 1'b0;
          end else if (redirect) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_enable = ~stall_id;
          end
        end
        REDIR_PEND: begin
          iREN = 1'b1;
          if (halt) begin
            if_id_flush = 1'b0;
          end else begin
            if_id_flush = redirect;
          end
        end
        HALTED: begin
          iREN = 1'b0;
        end
        default: begin
          iREN = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random traffic,
// checked against a rule-level reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        if_id_enable;
  logic        if_id_flush;
  logic [31:0] imemload_out;
  logic [31:0] pcp4_out;
  logic [31:0] pc_out;

  fetch_unit #(.WORD_W(32), .PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .stall_id(stall_id), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush), .imemload_out(imemload_out),
    .pcp4_out(pcp4_out), .pc_out(pc_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        iren;
    logic [31:0] load;
  } cyc_exp_t;

  typedef struct {
    bit          is_flush;
    logic [31:0] word;
    logic [31:0] pcp4;
  } ev_exp_t;

  cyc_exp_t cyc_q[$];
  ev_exp_t  ev_q[$];
  int n_total = 0;
  int n_bad   = 0;

  // Reference model: what the fetch stage is doing, in plain terms.
  logic [31:0] m_pc       = PC_INIT;
  bit          m_held     = 1'b0;
  logic [31:0] m_held_word = 32'h0;
  bit          m_pend     = 1'b0;
  logic [31:0] m_pend_pc  = 32'h0;
  bit          m_halted   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit fl, input logic [31:0] w, input logic [31:0] p4);
    ev_exp_t e;
    e.is_flush = fl;
    e.word     = w;
    e.pcp4     = p4;
    ev_q.push_back(e);
  endtask

  task automatic model_cycle(input bit rst, input bit hit, input bit stall, input bit redir,
                             input logic [31:0] rpc, input bit hlt, input logic [31:0] load);
    cyc_exp_t c;
    logic [31:0] tgt;
    c.addr = m_pc;
    c.iren = !rst && !m_halted && !m_held;
    c.load = m_held ? m_held_word : load;
    cyc_q.push_back(c);
    tgt = rpc & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = PC_INIT; m_held = 1'b0; m_pend = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (hlt) begin
      m_halted = 1'b1; m_held = 1'b0; m_pend = 1'b0;
    end else if (redir) begin
      push_ev(1'b1, 32'h0, 32'h0);
      if (m_held) begin
        m_held = 1'b0; m_pc = tgt;
      end else if (hit) begin
        m_pend = 1'b0; m_pc = tgt;
      end else begin
        m_pend = 1'b1; m_pend_pc = tgt;
      end
    end else if (m_pend) begin
      if (hit) begin
        m_pc = m_pend_pc; m_pend = 1'b0;
      end
    end else if (m_held) begin
      if (!stall) begin
        push_ev(1'b0, m_held_word, m_pc + 32'd4);
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else if (hit) begin
      if (stall) begin
        m_held = 1'b1; m_held_word = load;
      end else begin
        push_ev(1'b0, load, m_pc + 32'd4);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit hit, input bit stall, input bit redir,
                       input logic [31:0] rpc, input bit hlt, input logic [31:0] load);
    @(posedge CLK);
    #1;
    RST = rst; ihit = hit; stall_id = stall; redirect = redir;
    redirect_pc = rpc; halt = hlt; imemload = load;
    model_cycle(rst, hit, stall, redir, rpc, hlt, load);
  endtask

  // Monitor: per-cycle outputs every cycle, latch events when presented.
  always @(negedge CLK) begin
    cyc_exp_t c;
    ev_exp_t  e;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("imemaddr", imemaddr, c.addr);
      chk("pc_out", pc_out, c.addr);
      chk("pcp4_out", pcp4_out, c.addr + 32'd4);
      chk("iREN", {31'b0, iREN}, {31'b0, c.iren});
      chk("imemload_out", imemload_out, c.load);
      chk("en_flush_excl", {31'b0, if_id_enable & if_id_flush}, 32'h0);
      if (if_id_enable || if_id_flush) begin
        if (ev_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL unexpected_event: enable=%0b flush=%0b expected none at %0t",
                   if_id_enable, if_id_flush, $time);
        end else begin
          e = ev_q.pop_front();
          chk("event_is_flush", {31'b0, if_id_flush}, {31'b0, e.is_flush});
          if (!e.is_flush) begin
            chk("latched_word", imemload_out, e.word);
            chk("latched_pcp4", pcp4_out, e.pcp4);
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    // sequential fetch 0,4,8,C
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 32'h0, 0, 32'hA000_0000 + i);
    // stall at 0x10 for 3 cycles, then release
    drive(0, 1, 1, 0, 32'h0, 0, 32'h2001_0005);
    drive(0, 1, 1, 0, 32'h0, 0, 32'hDEAD_BEEF);
    drive(0, 0, 1, 0, 32'h0, 0, 32'hBAD0_0BAD);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 32'h0, 0, 32'hB000_0000 + i);
    // redirect during a miss at 0x20
    drive(0, 0, 0, 1, 32'h0000_0103, 0, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hC0DE_0020);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hC0DE_0100);
    // halt wins over redirect, stays halted, reset recovers
    drive(0, 1, 0, 1, 32'h0000_0040, 1, 32'h0);
    for (int i = 0; i < 10; i++)
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hD000_0000);
    // PC wrap at 0xFFFF_FFFC
    drive(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hE000_FFFC);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hE000_0000);
    // reset while a redirect is pending
    drive(0, 0, 0, 1, 32'h0000_0080, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hF000_0000);
    drive(0, 1, 0, 0, 32'h0, 0, 32'hF000_0004);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
            $urandom, ($urandom_range(0, 199) < 1), $urandom);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge CLK);
    n_total++;
    if (ev_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d left over expected 0", ev_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
